// File: rtl/mem_arbiter_pkg.sv
// Shared types for the L1-to-pmem arbiter: line/word widths, FSM states, grant owner.
package mem_arbiter_pkg;

  localparam int ARB_LINE_W = 128;
  localparam int ARB_ADDR_W = 16;

  typedef logic [ARB_LINE_W-1:0] lc3b_cacheline;
  typedef logic [ARB_ADDR_W-1:0] lc3b_word;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_RD,
    D_WR,
    I_RESP,
    D_RESP
  } arb_state_e;

  typedef enum logic {
    ICACHE,
    DCACHE
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory line ports seen by the arbiter.
interface mem_arbiter_if #(
  parameter int LINE_W = mem_arbiter_pkg::ARB_LINE_W,
  parameter int ADDR_W = mem_arbiter_pkg::ARB_ADDR_W
);

  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // The arbiter's view: cache requests and memory completions come in.
  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // The surrounding system's view: caches and memory.
  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/mem_arbiter_control.sv
// Arbiter FSM: round-robin grant between I and D caches, holds the grant for a whole
// pmem transaction, then spends one cycle pulsing the owner's resp before re-arbitrating.
module arbiter_control
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_req_i,
  input  logic d_read_i,
  input  logic d_write_i,
  input  logic pmem_resp_i,
  output logic load_addr_o,
  output logic addr_sel_d_o,
  output logic load_wdata_o,
  output logic load_line_o,
  output logic pmem_read_o,
  output logic pmem_write_o,
  output logic icache_resp_o,
  output logic dcache_resp_o
);

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  logic       d_req;

  // A write with read also high is a protocol error and is served as a write.
  assign d_req = d_read_i | d_write_i;

  // State and last-grant registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= DCACHE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: arbitrate only in IDLE, so a resp cycle never overlaps a new grant.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req_i && (!d_req || last_grant_q == DCACHE)) begin
          state_d      = I_BUSY;
          last_grant_d = ICACHE;
        end else if (d_req) begin
          state_d      = d_write_i ? D_WR : D_RD;
          last_grant_d = DCACHE;
        end
      end
      I_BUSY:  if (pmem_resp_i) state_d = I_RESP;
      D_RD:    if (pmem_resp_i) state_d = D_RESP;
      D_WR:    if (pmem_resp_i) state_d = D_RESP;
      I_RESP:  state_d = IDLE;
      D_RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes, resp pulses and datapath load enables decoded from the current/next state.
  always_comb begin
    pmem_read_o   = (state_q == I_BUSY) || (state_q == D_RD);
    pmem_write_o  = (state_q == D_WR);
    icache_resp_o = (state_q == I_RESP);
    dcache_resp_o = (state_q == D_RESP);
    load_addr_o   = (state_q == IDLE) && (state_d != IDLE);
    addr_sel_d_o  = (state_d == D_RD) || (state_d == D_WR);
    load_wdata_o  = (state_q == IDLE) && (state_d == D_WR);
    load_line_o   = ((state_q == I_BUSY) || (state_q == D_RD)) && pmem_resp_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared pmem line-port arbiter for the L1 I and D caches. Address and write data are
// captured at grant so pmem sees stable values; the returned line is buffered for the resp.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_W = ARB_LINE_W,
  parameter int ADDR_W = ARB_ADDR_W
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic load_addr, addr_sel_d, load_wdata, load_line;
  logic pmem_read, pmem_write, icache_resp, dcache_resp;

  arbiter_control u_control (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req_i       (bus.icache_pmem_read),
    .d_read_i      (bus.dcache_pmem_read),
    .d_write_i     (bus.dcache_pmem_write),
    .pmem_resp_i   (bus.pmem_resp),
    .load_addr_o   (load_addr),
    .addr_sel_d_o  (addr_sel_d),
    .load_wdata_o  (load_wdata),
    .load_line_o   (load_line),
    .pmem_read_o   (pmem_read),
    .pmem_write_o  (pmem_write),
    .icache_resp_o (icache_resp),
    .dcache_resp_o (dcache_resp)
  );

  // Next values for the address, write-data and line-buffer registers.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    if (load_addr) begin
      addr_d = addr_sel_d ? bus.dcache_pmem_address : bus.icache_pmem_address;
    end
    if (load_wdata) begin
      wdata_d = bus.dcache_pmem_wdata;
    end
    if (load_line) begin
      line_d = bus.pmem_rdata;
    end
  end

  // Datapath registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
    end
  end

  assign bus.pmem_read         = pmem_read;
  assign bus.pmem_write        = pmem_write;
  assign bus.pmem_address      = addr_q;
  assign bus.pmem_wdata        = wdata_q;
  assign bus.icache_pmem_resp  = icache_resp;
  assign bus.dcache_pmem_resp  = dcache_resp;
  assign bus.icache_pmem_rdata = line_q;
  assign bus.dcache_pmem_rdata = line_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates between the L1 instruction cache and the L1 data cache for one shared physical-memory (pmem) line port.
- Sits directly downstream of the two L1 caches that serve the pipeline's i_mem and d_mem ports.
- Each cache miss, whether a line fill or a dirty write-back, becomes one pmem transaction.
- Holds the grant for the whole transaction, buffers the returned line, and returns a one-cycle response to the owning cache.

Parameters:
- LINE_W, 128, cache line width in bits
- ADDR_W, 16, byte address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- icache_pmem_read  in  1  I-cache line-fill request; held until icache_pmem_resp
- icache_pmem_address  in  ADDR_W  I-cache line address
- icache_pmem_rdata  out  LINE_W  buffered fill line for the I-cache
- icache_pmem_resp  out  1  one-cycle completion pulse to the I-cache
- dcache_pmem_read  in  1  D-cache line-fill request; held until dcache_pmem_resp
- dcache_pmem_write  in  1  D-cache write-back request; held until dcache_pmem_resp
- dcache_pmem_address  in  ADDR_W  D-cache line address
- dcache_pmem_wdata  in  LINE_W  D-cache write-back line
- dcache_pmem_rdata  out  LINE_W  buffered fill line for the D-cache
- dcache_pmem_resp  out  1  one-cycle completion pulse to the D-cache
- pmem_read  out  1  read strobe to physical memory
- pmem_write  out  1  write strobe to physical memory
- pmem_address  out  ADDR_W  physical-memory address
- pmem_wdata  out  LINE_W  physical-memory write line
- pmem_rdata  in  LINE_W  physical-memory read line
- pmem_resp  in  1  physical memory done; valid for one cycle

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: on a rising clk edge with reset_n=0, every register loads its reset value.
- Reset values:
  - state = IDLE, last_grant = DCACHE, line buffer = 0.
  - All outputs are 0: both resp, pmem_read, pmem_write, pmem_address, pmem_wdata and both rdata outputs.
- States: IDLE, I_BUSY, D_RD, D_WR, I_RESP, D_RESP.
- IDLE:
  - No pmem strobes are asserted.
  - Only I requesting -> I_BUSY. Only D requesting -> D_WR if dcache_pmem_write, else D_RD.
  - Both requesting -> grant the port opposite last_grant (round-robin).
  - last_grant updates on every grant.
- Address/data capture: on entry to a BUSY state, the granted address, and wdata for D_WR, are captured into registers. pmem_address and pmem_wdata drive from those registers, so they are stable for the whole transaction even if the cache changes its inputs.
- I_BUSY / D_RD: pmem_read=1.
  - On pmem_resp, latch pmem_rdata into the line buffer and go to I_RESP / D_RESP.
- D_WR: pmem_write=1.
  - On pmem_resp go to D_RESP; the line buffer is unchanged.
- I_RESP / D_RESP:
  - The owner's resp=1 for exactly one cycle; its rdata drives the line buffer.
  - Strobes are 0. Unconditionally return to IDLE.
- rdata outputs: both icache_pmem_rdata and dcache_pmem_rdata always drive the line buffer; the value is meaningful only while the matching resp is high.
- Latency: request seen in IDLE at cycle 0 -> strobe at cycle 1. pmem_resp at cycle k -> cache resp at k+1 -> earliest new grant at k+2. Minimum turnaround is 3 cycles plus memory latency.
- Handshake rules:
  - A requester must hold its request until it sees resp, then drop it in the following cycle.
  - The arbiter does not re-grant in the resp cycle.
- Boundary conditions:
  - dcache_pmem_read and dcache_pmem_write both high: a protocol error; treated as a write.
  - Request deasserted mid-transaction: ignored. The transaction completes and resp still pulses.
  - pmem_resp while in IDLE or a RESP state: ignored.
  - A new request arriving during a transaction waits; no request is dropped.
  - Round-robin prevents starvation: with both caches requesting continuously, grants strictly alternate.
  - reset_n low mid-transaction: immediately IDLE with all outputs 0. A later pmem_resp from the aborted transaction is ignored.

Decomposition:
- Shared package (lc3b_types):
  - lc3b_cacheline typedef (LINE_W bits); address uses the existing lc3b_word.
  - arbiter state enum; grant enum {ICACHE, DCACHE}.
- Sub-module: one natural sub-module, arbiter_control, containing the FSM, next-state logic and last_grant.
- Datapath regs (address, wdata, line buffer) stay in the top module, built from the existing register module.

Test Plan:
- Single I-fill: icache_pmem_read=1, addr=0x1230; pmem_resp after 4 cycles with rdata=0xDEAD...BEEF -> pmem_read high cycles 1-4 with pmem_address=0x1230; icache_pmem_resp pulses at cycle 5 with that line; dcache_pmem_resp stays 0.
- D write-back: dcache_pmem_write=1, addr=0x8000, wdata=0xA5 repeated -> pmem_write=1, pmem_wdata=0xA5..A5 until pmem_resp; dcache_pmem_resp pulses one cycle later; line buffer unchanged.
- Simultaneous requests after reset: I addr 0x0040, D read addr 0x2000 -> I granted first (last_grant resets to DCACHE); D granted at earliest k+2; pmem_address=0x2000 in the second transaction.
- Continuous contention: both hold requests, drop each for one cycle after resp and re-raise -> grants alternate I, D, I, D over 4 transactions; no consecutive double grant.
- Input churn: change dcache_pmem_address 0x2000 -> 0x3000 mid-D_RD -> pmem_address stays 0x2000 until resp.
- Mid-operation reset: reset_n=0 during I_BUSY, then pmem_resp arrives one cycle after release -> all outputs 0; no resp pulse; state IDLE.
